// File: rtl/exu_issue_sched_pkg.sv
// MCU-wide defines (cycle-count width, scheduler state codes, queue depth)
// and the shared types/helpers of the EXU issue scheduler.
`ifndef MCU_DEFINES_V
`define MCU_DEFINES_V
`define MAX_DELAY_WIDTH 8
`define IS_ST_RUN 1'b0
`define IS_ST_TRAP 1'b1
`define IS_FIFO_DEPTH 2
`endif

package exu_issue_sched_pkg;

  localparam int IS_DW    = `MAX_DELAY_WIDTH;
  localparam int IS_DEPTH = `IS_FIFO_DEPTH;
  localparam int IS_PTR_W = $clog2(IS_DEPTH);

  typedef enum logic {
    ST_RUN  = `IS_ST_RUN,
    ST_TRAP = `IS_ST_TRAP
  } is_state_e;

  // Ring-pointer advance, wrapping at the queue depth.
  function automatic logic [IS_PTR_W-1:0] ptr_inc(input logic [IS_PTR_W-1:0] p);
    logic [IS_PTR_W-1:0] r;
    if (p == IS_PTR_W'(IS_DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exu_issue_sched_if.sv
// Fetch, configuration, execute and trap signals of the issue scheduler.
interface exu_issue_sched_if
  import exu_issue_sched_pkg::*;
#(
  parameter int DW    = IS_DW,
  parameter int CLS_W = 3
);
  logic             is_i_ifu_valid;
  logic             is_o_ifu_ready;
  logic [31:0]      is_i_ifu_pc;
  logic [CLS_W-1:0] is_i_ifu_cls;
  logic             is_i_cfg_we;
  logic [CLS_W-1:0] is_i_cfg_idx;
  logic [DW-1:0]    is_i_cfg_cyc;
  logic             is_o_exu_valid;
  logic [31:0]      is_o_exu_pc;
  logic [DW-1:0]    is_o_pc_cycle;
  logic             is_i_exu_ready;
  logic             is_i_delay_err;
  logic             is_i_flush;
  logic             is_o_trap;
  logic [31:0]      is_o_trap_pc;

  modport master (
    output is_i_ifu_valid, is_i_ifu_pc, is_i_ifu_cls,
    output is_i_cfg_we, is_i_cfg_idx, is_i_cfg_cyc,
    output is_i_exu_ready, is_i_delay_err, is_i_flush,
    input  is_o_ifu_ready, is_o_exu_valid, is_o_exu_pc, is_o_pc_cycle,
    input  is_o_trap, is_o_trap_pc
  );

  modport slave (
    input  is_i_ifu_valid, is_i_ifu_pc, is_i_ifu_cls,
    input  is_i_cfg_we, is_i_cfg_idx, is_i_cfg_cyc,
    input  is_i_exu_ready, is_i_delay_err, is_i_flush,
    output is_o_ifu_ready, is_o_exu_valid, is_o_exu_pc, is_o_pc_cycle,
    output is_o_trap, is_o_trap_pc
  );
endinterface

// File: rtl/exu_issue_sched_fifo2.sv
// Two-entry FIFO with synchronous clear; the output reads zero when empty.
module is_fifo2
  import exu_issue_sched_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0]        r_mem [IS_DEPTH];
  logic [IS_PTR_W-1:0] r_wptr;
  logic [IS_PTR_W-1:0] r_rptr;
  logic [IS_PTR_W:0]   r_cnt;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_cnt == (IS_PTR_W + 1)'(IS_DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  // Pointers and occupancy; clear wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IS_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_clr) begin
      r_mem[r_wptr] <= i_din;
    end
  end
endmodule

// File: rtl/exu_issue_sched.sv
// Issue scheduler: queues fetched instructions with their class cycle cost
// and presents them to the executor; a delay error traps until flushed.
module exu_issue_sched
  import exu_issue_sched_pkg::*;
#(
  parameter int DW    = `MAX_DELAY_WIDTH,
  parameter int CLS_W = 3
) (
  input logic               clk,
  input logic               rst_n,
  exu_issue_sched_if.slave  bus
);
  localparam int TBL_N = 2 ** CLS_W;
  localparam int ENT_W = 32 + DW;

  is_state_e        r_state;
  is_state_e        w_state_nxt;
  logic [DW-1:0]    r_tbl [TBL_N];
  logic             r_trap;
  logic [31:0]      r_trap_pc;
  logic             w_run;
  logic             w_full;
  logic             w_empty;
  logic             w_ifu_ready;
  logic             w_exu_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_trap_take;
  logic [ENT_W-1:0] w_din;
  logic [ENT_W-1:0] w_dout;

  assign w_run       = (r_state == ST_RUN);
  assign w_ifu_ready = w_run & ~w_full;
  assign w_exu_valid = w_run & ~w_empty;
  assign w_trap_take = w_run & bus.is_i_delay_err;
  assign w_clr       = w_run & (bus.is_i_delay_err | bus.is_i_flush);
  assign w_push      = bus.is_i_ifu_valid & w_ifu_ready & ~w_clr;
  assign w_pop       = w_exu_valid & bus.is_i_exu_ready;
  // Cycle cost is frozen at enqueue from the registered table (pre-write value).
  assign w_din       = {bus.is_i_ifu_pc, r_tbl[bus.is_i_ifu_cls]};

  assign bus.is_o_ifu_ready = w_ifu_ready;
  assign bus.is_o_exu_valid = w_exu_valid;
  assign bus.is_o_exu_pc    = w_dout[ENT_W-1:DW];
  assign bus.is_o_pc_cycle  = w_dout[DW-1:0];
  assign bus.is_o_trap      = r_trap;
  assign bus.is_o_trap_pc   = r_trap_pc;

  is_fifo2 #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Class cycle table; a zero cost is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) r_tbl[i] <= DW'(1'b1);
    end else if (bus.is_i_cfg_we && (bus.is_i_cfg_cyc != '0)) begin
      r_tbl[bus.is_i_cfg_idx] <= bus.is_i_cfg_cyc;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: delay error traps, flush releases the trap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.is_i_delay_err) w_state_nxt = ST_TRAP;
        else                    w_state_nxt = ST_RUN;
      end
      ST_TRAP: begin
        if (bus.is_i_flush) w_state_nxt = ST_RUN;
        else                w_state_nxt = ST_TRAP;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Trap pulse and the head PC captured on entry to TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap    <= 1'b0;
      r_trap_pc <= 32'h0;
    end else begin
      r_trap <= w_trap_take;
      if (w_trap_take) r_trap_pc <= bus.is_o_exu_pc;
    end
  end
endmodule
